// File: rtl/instruction_memory_pipelined_pkg.sv
// Shared constants and types for the pipelined instruction memory.
// Holds the FSM encoding, the cleared-word value and the response bundle.
package instruction_memory_pipelined_pkg;

    localparam int IMEM_WORD_SIZE = 19;

    localparam logic [IMEM_WORD_SIZE-1:0] NOP_WORD = '0;

    typedef enum logic [0:0] {
        IM_CLEAR = 1'b0,
        IM_READY = 1'b1
    } imem_state_e;

    typedef struct packed {
        logic                      fault;
        logic [IMEM_WORD_SIZE-1:0] word;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO between the array read pipe and fetch.
// Push while full is only taken when a pop frees the slot in the same cycle.
module imem_rsp_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (32'(cnt_q) == DEPTH);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = do_push ? nxt(wr_q) : wr_q;
        rd_d  = do_pop ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Single-port program store with a load port and a pipelined fetch port.
// The array is zeroed by a sweep after reset; loads win over fetches.
module instruction_memory_pipelined
    import instruction_memory_pipelined_pkg::*;
#(
    parameter int WORD_SIZE    = 19,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  init_done,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [WORD_SIZE-1:0]  ld_data,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_rsp_valid,
    input  logic                  fetch_rsp_ready,
    output logic [WORD_SIZE-1:0]  instruction,
    output logic                  fetch_fault
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int RW = WORD_SIZE + 1;

    imem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;
    logic [WORD_SIZE-1:0]  mem_q [DEPTH];
    logic [WORD_SIZE-1:0]  rdata_q;
    logic                  p1_vld_q, p1_flt_q;
    logic [WORD_SIZE-1:0]  p1_word;
    logic [RW-1:0]         p1_data;
    logic [WORD_SIZE-1:0]  last_word_q;
    logic                  last_flt_q;

    logic                  ld_hit;
    logic                  fetch_acc, fetch_hit;
    logic                  rsp_hs, clr_last;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [WORD_SIZE-1:0]  wdata;
    logic                  push, push_ok;
    logic [RW-1:0]         push_data, head;
    logic                  fifo_full, fifo_empty;

    assign init_done = (state_q == IM_READY);
    assign ld_ready  = (state_q == IM_READY);

    assign fetch_req_ready = (state_q == IM_READY)
                          && !ld_valid
                          && (32'(out_cnt_q) < RSP_DEPTH);

    assign ld_hit    = ld_valid && ld_ready
                    && (32'(ld_addr) < DEPTH);
    assign fetch_acc = fetch_req_valid && fetch_req_ready;
    assign fetch_hit = fetch_acc
                    && (32'(fetch_addr) < DEPTH);
    assign rsp_hs    = fetch_rsp_valid && fetch_rsp_ready;
    assign clr_last  = (32'(clr_ptr_q) == DEPTH - 1);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            IM_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_last) begin
                    state_d = IM_READY;
                end
            end
            IM_READY: state_d = IM_READY;
        endcase
    end

    // Counts fetches from accept until the consumer takes the response.
    always_comb begin
        out_cnt_d = out_cnt_q;
        unique case ({fetch_acc, rsp_hs})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IM_CLEAR;
            clr_ptr_q   <= '0;
            out_cnt_q   <= '0;
            p1_vld_q    <= 1'b0;
            p1_flt_q    <= 1'b0;
            last_word_q <= '0;
            last_flt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            out_cnt_q <= out_cnt_d;
            p1_vld_q  <= fetch_acc;
            p1_flt_q  <= fetch_acc && !fetch_hit;
            if (!fifo_empty) begin
                {last_flt_q, last_word_q} <= head;
            end
        end
    end

    assign we    = !RESET
                && ((state_q == IM_CLEAR) || ld_hit);
    assign waddr = (state_q == IM_CLEAR) ? clr_ptr_q : ld_addr;
    assign wdata = (state_q == IM_CLEAR)
                 ? WORD_SIZE'(NOP_WORD) : ld_data;

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (fetch_hit) begin
            rdata_q <= mem_q[fetch_addr];
        end
    end

    // A faulting fetch never reads the array, so its stale data is masked.
    assign p1_word = p1_flt_q ? '0 : rdata_q;
    assign p1_data = {p1_flt_q, p1_word};

    if (READ_LATENCY == 2) begin : g_lat2
        logic          p2_vld_q;
        logic [RW-1:0] p2_data_q;

        always_ff @(posedge CLK) begin
            if (RESET) begin
                p2_vld_q  <= 1'b0;
                p2_data_q <= '0;
            end else begin
                p2_vld_q  <= p1_vld_q;
                p2_data_q <= p1_data;
            end
        end

        assign push      = p2_vld_q;
        assign push_data = p2_data_q;
    end else begin : g_lat1
        assign push      = p1_vld_q;
        assign push_data = p1_data;
    end

    assign push_ok = push && (!fifo_full || rsp_hs);

    imem_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push_ok),
        .data_i  (push_data),
        .pop_i   (rsp_hs),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fetch_rsp_valid = !fifo_empty;
    assign instruction = fifo_empty
                       ? last_word_q : head[WORD_SIZE-1:0];
    assign fetch_fault = fifo_empty
                       ? last_flt_q : head[WORD_SIZE];

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Bench for two instruction memory configurations against a queue model.
// Instance 0: DEPTH 1024, latency 1. Instance 1: DEPTH 1000, latency 2.
module tb_instruction_memory_pipelined;
    localparam int W    = 19;
    localparam int AW   = 10;
    localparam int RSPD = 2;
    localparam int DEP0 = 1024;
    localparam int DEP1 = 1000;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0]    rst, ldv, frv, frr;
    logic [1:0]    done, ldr, frq, rsv, flt;
    logic [AW-1:0] lda [2];
    logic [W-1:0]  ldd [2];
    logic [AW-1:0] fra [2];
    logic [W-1:0]  ins [2];

    instruction_memory_pipelined #(
        .WORD_SIZE(W), .DEPTH(DEP0), .ADDR_WIDTH(AW),
        .READ_LATENCY(1), .RSP_DEPTH(RSPD)
    ) u_dut0 (
        .CLK(CLK), .RESET(rst[0]), .init_done(done[0]),
        .ld_valid(ldv[0]), .ld_ready(ldr[0]),
        .ld_addr(lda[0]), .ld_data(ldd[0]),
        .fetch_req_valid(frv[0]), .fetch_req_ready(frq[0]),
        .fetch_addr(fra[0]), .fetch_rsp_valid(rsv[0]),
        .fetch_rsp_ready(frr[0]), .instruction(ins[0]),
        .fetch_fault(flt[0])
    );

    instruction_memory_pipelined #(
        .WORD_SIZE(W), .DEPTH(DEP1), .ADDR_WIDTH(AW),
        .READ_LATENCY(2), .RSP_DEPTH(RSPD)
    ) u_dut1 (
        .CLK(CLK), .RESET(rst[1]), .init_done(done[1]),
        .ld_valid(ldv[1]), .ld_ready(ldr[1]),
        .ld_addr(lda[1]), .ld_data(ldd[1]),
        .fetch_req_valid(frv[1]), .fetch_req_ready(frq[1]),
        .fetch_addr(fra[1]), .fetch_rsp_valid(rsv[1]),
        .fetch_rsp_ready(frr[1]), .instruction(ins[1]),
        .fetch_fault(flt[1])
    );

    // Reference model: memory image plus an ordered list of responses
    // each tagged with the clock edge from which it becomes visible.
    int           dep [2] = '{DEP0, DEP1};
    int           rl [2]  = '{1, 2};
    logic [W-1:0] mm [2][1024];
    int           pr [2][8];
    logic [W-1:0] pw [2][8];
    logic         pf [2][8];
    int           ph [2]    = '{0, 0};
    int           pn [2]    = '{0, 0};
    int           since [2] = '{0, 0};
    logic [W-1:0] lw [2];
    logic         lf [2];
    bit           seen [2]  = '{0, 0};
    int           ecnt   = 0;
    int           checks = 0;
    int           fails  = 0;
    int           nprint = 0;

    function automatic bit m_done(input int k);
        return since[k] >= dep[k];
    endfunction

    function automatic bit m_valid(input int k);
        return pn[k] > 0 && pr[k][ph[k]] <= ecnt;
    endfunction

    function automatic bit m_rqr(input int k);
        return m_done(k) && !ldv[k] && pn[k] < RSPD;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (nprint < 40) begin
                $display("FAIL %s: got %0h expected %0h",
                         nm, act, exp);
            end
            nprint++;
        end
    endtask

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                seen[k]  = 1'b1;
                pn[k]    = 0;
                ph[k]    = 0;
                since[k] = 0;
                lw[k]    = '0;
                lf[k]    = 1'b0;
                for (int a = 0; a < 1024; a++) mm[k][a] = '0;
            end else if (seen[k]) begin
                bit hs, acc;
                int slot, a;
                hs  = m_valid(k) && frr[k];
                acc = frv[k] && m_rqr(k);
                if (ldv[k] && m_done(k)
                    && int'(lda[k]) < dep[k]) begin
                    mm[k][lda[k]] = ldd[k];
                end
                if (hs) begin
                    lw[k] = pw[k][ph[k]];
                    lf[k] = pf[k][ph[k]];
                    ph[k] = (ph[k] + 1) % 8;
                    pn[k]--;
                end
                if (acc) begin
                    slot = (ph[k] + pn[k]) % 8;
                    a    = int'(fra[k]);
                    pr[k][slot] = ecnt + 1 + rl[k];
                    pf[k][slot] = (a >= dep[k]);
                    pw[k][slot] = (a >= dep[k]) ? '0 : mm[k][a];
                    pn[k]++;
                end
                since[k]++;
            end
        end
        ecnt++;
    end

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (seen[k]) begin
                chk($sformatf("d%0d init_done", k),
                    32'(done[k]), 32'(m_done(k)));
                chk($sformatf("d%0d ld_ready", k),
                    32'(ldr[k]), 32'(m_done(k)));
                chk($sformatf("d%0d fetch_req_ready", k),
                    32'(frq[k]), 32'(m_rqr(k)));
                chk($sformatf("d%0d fetch_rsp_valid", k),
                    32'(rsv[k]), 32'(m_valid(k)));
                chk($sformatf("d%0d instruction", k),
                    32'(ins[k]),
                    32'(m_valid(k) ? pw[k][ph[k]] : lw[k]));
                chk($sformatf("d%0d fetch_fault", k),
                    32'(flt[k]),
                    32'(m_valid(k) ? pf[k][ph[k]] : lf[k]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_init(input int k, output int n);
        n = 0;
        while (!done[k] && n < 1200) begin
            tick();
            n++;
        end
    endtask

    task automatic load(input int k, input int a,
                        input logic [W-1:0] d);
        ldv[k] = 1'b1;
        lda[k] = AW'(a);
        ldd[k] = d;
        tick();
        ldv[k] = 1'b0;
    endtask

    task automatic fetch(input int k, input int a,
                         output logic [W-1:0] w,
                         output logic f, output int lat);
        int n;
        bit ok;
        frv[k] = 1'b1;
        fra[k] = AW'(a);
        frr[k] = 1'b1;
        n  = 0;
        ok = 1'b0;
        w  = '0;
        f  = 1'b0;
        while (!ok && n < 50) begin
            #1;
            ok = frq[k];
            tick();
            n++;
        end
        frv[k] = 1'b0;
        lat = 0;
        if (!ok) begin
            lat = -1;
            return;
        end
        while (!rsv[k] && lat < 50) begin
            tick();
            lat++;
        end
        w = ins[k];
        f = flt[k];
        tick();
    endtask

    task automatic fetch_chk(input int k, input int a,
                             input logic [W-1:0] ew,
                             input logic ef, input string nm);
        logic [W-1:0] w;
        logic         f;
        int           lat;
        fetch(k, a, w, f, lat);
        chk($sformatf("d%0d %s word", k, nm), 32'(w), 32'(ew));
        chk($sformatf("d%0d %s fault", k, nm), 32'(f), 32'(ef));
        chk($sformatf("d%0d %s latency", k, nm), lat, rl[k]);
    endtask

    task automatic scenario(input int k);
        int           n, got;
        bit           hs, ac;
        logic [W-1:0] wv;
        logic [W-1:0] rw [4];
        int           a;

        ldv[k] = 1'b0;
        frv[k] = 1'b0;
        frr[k] = 1'b1;
        rst[k] = 1'b1;
        tick();
        #1;
        chk($sformatf("d%0d rst init_done", k), 32'(done[k]), 0);
        chk($sformatf("d%0d rst readies", k),
            32'({ldr[k], frq[k]}), 0);
        chk($sformatf("d%0d rst rsp_valid", k), 32'(rsv[k]), 0);
        chk($sformatf("d%0d rst instr", k),
            32'({flt[k], ins[k]}), 0);
        rst[k] = 1'b0;
        wait_init(k, n);
        chk($sformatf("d%0d init latency", k), n, dep[k]);
        fetch_chk(k, 5, 19'h0, 1'b0, "cleared addr5");

        load(k, 3, 19'h5A5A5);
        fetch_chk(k, 3, 19'h5A5A5, 1'b0, "raw addr3");

        load(k, 1, 19'h11111);
        load(k, 2, 19'h22222);
        load(k, 3, 19'h33333);
        frr[k] = 1'b0;
        frv[k] = 1'b1;
        fra[k] = AW'(1);
        #1;
        chk($sformatf("d%0d bp req1 ready", k), 32'(frq[k]), 1);
        tick();
        fra[k] = AW'(2);
        #1;
        chk($sformatf("d%0d bp req2 ready", k), 32'(frq[k]), 1);
        tick();
        fra[k] = AW'(3);
        #1;
        chk($sformatf("d%0d bp req3 stall", k), 32'(frq[k]), 0);
        tick();
        tick();
        tick();
        #1;
        chk($sformatf("d%0d bp hold valid", k), 32'(rsv[k]), 1);
        chk($sformatf("d%0d bp hold word", k), 32'(ins[k]),
            32'(19'h11111));
        frr[k] = 1'b1;
        got = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            hs = rsv[k] && frr[k];
            wv = ins[k];
            ac = frv[k] && frq[k];
            tick();
            if (hs) begin
                if (got < 4) rw[got] = wv;
                got++;
            end
            if (ac) frv[k] = 1'b0;
        end
        chk($sformatf("d%0d bp rsp count", k), got, 3);
        chk($sformatf("d%0d bp rsp0", k), 32'(rw[0]), 32'(19'h11111));
        chk($sformatf("d%0d bp rsp1", k), 32'(rw[1]), 32'(19'h22222));
        chk($sformatf("d%0d bp rsp2", k), 32'(rw[2]), 32'(19'h33333));

        ldv[k] = 1'b1;
        lda[k] = AW'(7);
        ldd[k] = 19'h00123;
        frv[k] = 1'b1;
        fra[k] = AW'(7);
        #1;
        chk($sformatf("d%0d prio fetch blocked", k), 32'(frq[k]), 0);
        tick();
        ldv[k] = 1'b0;
        fetch_chk(k, 7, 19'h00123, 1'b0, "prio addr7");

        load(k, dep[k] - 1, 19'h4BCDE);
        fetch_chk(k, dep[k] - 1, 19'h4BCDE, 1'b0, "top addr");
        if (k == 1) begin
            fetch_chk(k, 1000, 19'h0, 1'b1, "addr1000");
            fetch_chk(k, 1010, 19'h0, 1'b1, "addr1010");
            #1;
            chk("d1 oob load ready", 32'(ldr[k]), 1);
            load(k, 1010, 19'h7FFFF);
            fetch_chk(k, 10, 19'h0, 1'b0, "alias addr10");
            fetch_chk(k, 999, 19'h4BCDE, 1'b0, "addr999 kept");
            fetch_chk(k, 1010, 19'h0, 1'b1, "addr1010 again");
        end

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0)
              ? $urandom_range(990, 1023) : $urandom_range(0, 15);
            ldv[k] = ($urandom_range(0, 3) == 0);
            lda[k] = AW'(a);
            ldd[k] = W'($urandom);
            a = ($urandom_range(0, 7) == 0)
              ? $urandom_range(990, 1023) : $urandom_range(0, 15);
            frv[k] = 1'($urandom_range(0, 1));
            fra[k] = AW'(a);
            frr[k] = ($urandom_range(0, 2) != 0);
            tick();
        end
        ldv[k] = 1'b0;
        frv[k] = 1'b0;
        frr[k] = 1'b1;
        repeat (10) tick();

        load(k, 9, 19'h1ABCD);
        frr[k] = 1'b0;
        frv[k] = 1'b1;
        fra[k] = AW'(9);
        tick();
        tick();
        frv[k] = 1'b0;
        repeat (3) tick();
        #1;
        chk($sformatf("d%0d pre-rst valid", k), 32'(rsv[k]), 1);
        rst[k] = 1'b1;
        tick();
        #1;
        chk($sformatf("d%0d mid-rst valid", k), 32'(rsv[k]), 0);
        rst[k] = 1'b0;
        frr[k] = 1'b1;
        wait_init(k, n);
        chk($sformatf("d%0d re-init latency", k), n, dep[k]);
        fetch_chk(k, 9, 19'h0, 1'b0, "addr9 cleared");
    endtask

    initial begin
        rst = 2'b11;
        ldv = 2'b00;
        frv = 2'b00;
        frr = 2'b11;
        for (int k = 0; k < 2; k++) begin
            lda[k] = '0;
            ldd[k] = '0;
            fra[k] = '0;
            lw[k]  = '0;
            lf[k]  = 1'b0;
        end
        tick();
        rst = 2'b00;
        scenario(0);
        scenario(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/instruction_memory_pipelined.md
Name: instruction_memory_pipelined

Overview:
- Parametrised successor to the single-cycle instruction store of the 19-bit CPU.
- Holds program words in a single-port array and exposes two ports:
  - a program-load write port (valid/ready);
  - a fetch request/response pair (valid/ready on both sides) with configurable read latency.
- Memory is cleared by a sequential sweep after reset, not in one cycle.
- Sits between the fetch stage and the program loader; out-of-range fetches are flagged as faults.

Parameters:
- WORD_SIZE, 19, instruction word width in bits.
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 10, address width in bits.
- READ_LATENCY, 1, cycles from accepted fetch to array data available; legal values 1 or 2.
- RSP_DEPTH, 2, response buffer entries; also the maximum number of outstanding fetches.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- init_done  out  1  high once the clear sweep has completed.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted when ld_valid && ld_ready.
- ld_addr  in  ADDR_WIDTH  load address.
- ld_data  in  WORD_SIZE  load data.
- fetch_req_valid  in  1  fetch request.
- fetch_req_ready  out  1  fetch accepted when fetch_req_valid && fetch_req_ready.
- fetch_addr  in  ADDR_WIDTH  fetch address.
- fetch_rsp_valid  out  1  response available.
- fetch_rsp_ready  in  1  consumer takes the response.
- instruction  out  WORD_SIZE  response word.
- fetch_fault  out  1  response corresponds to an address >= DEPTH.

Behaviour:
- Reset (RESET high at a CLK edge):
  - FSM enters IM_CLEAR and the clear pointer is set to 0.
  - Response buffer is emptied, in-flight pipeline is flushed, outstanding count is set to 0.
  - Outputs: init_done=0, ld_ready=0, fetch_req_ready=0, fetch_rsp_valid=0, instruction=0, fetch_fault=0.
  - RESET mid-operation discards all outstanding fetches and restarts the sweep from address 0.
- IM_CLEAR:
  - Writes NOP_WORD (all zeros) at the clear pointer each cycle and increments the pointer.
  - After writing DEPTH-1, transitions to IM_READY on the next edge and sets init_done=1.
  - Sweep takes exactly DEPTH cycles. Both request readies stay 0 throughout.
- IM_READY:
  - ld_ready = 1, independent of the fetch port.
  - A load with ld_addr < DEPTH writes ld_data at the edge.
  - A load with ld_addr >= DEPTH is accepted and silently dropped.
- Port priority (single-port array): a load has priority over a fetch.
  - fetch_req_ready = (state==IM_READY) && !ld_valid && (outstanding < RSP_DEPTH).
- Outstanding count:
  - +1 on fetch accept; -1 on response handshake (fetch_rsp_valid && fetch_rsp_ready).
  - Both in the same cycle leaves it unchanged.
  - This guarantees no response is ever dropped under back-pressure.
- Fetch timing:
  - Fetch accepted at edge t; its array data enters the response buffer at edge t+READ_LATENCY.
  - fetch_rsp_valid rises in the cycle after that edge when the buffer was empty.
  - READ_LATENCY=2 inserts one pipeline register between array and buffer.
- Fault handling: when fetch_addr >= DEPTH, the array is not read; the response carries instruction=0 and fetch_fault=1 with the same latency.
- Ordering: responses are returned strictly in request order.
- Read-after-write: a load accepted at edge t followed by a fetch of the same address accepted at edge t+1 returns the new data.
- Response buffer:
  - FIFO of RSP_DEPTH entries, each {fault, word}.
  - instruction and fetch_fault are driven from the head entry and held stable while fetch_rsp_valid && !fetch_rsp_ready.
  - Simultaneous push and pop is legal when full or empty.
  - When the buffer is empty, instruction and fetch_fault hold their last value.

Decomposition:
- Package constants gains:
  - NOP_WORD;
  - typedef enum imem_state_e {IM_CLEAR, IM_READY};
  - typedef struct imem_rsp_t {logic fault; logic [WORD_SIZE-1:0] word;}.
- One sub-module: imem_rsp_fifo, a parametrised synchronous FIFO (DEPTH=RSP_DEPTH) with push/pop, full/empty, and the same CLK/RESET.

Test Plan:
1. Assert RESET for 1 cycle, then release -> init_done rises exactly 1024 cycles later; both readies stay 0 until then; a fetch of addr 5 afterwards returns 19'h0 with fault=0.
2. Load addr 3 = 19'h5A5A5, then fetch addr 3 on the next cycle with READ_LATENCY=1 -> fetch_rsp_valid 1 cycle after accept, instruction=19'h5A5A5; repeat with READ_LATENCY=2 -> valid 2 cycles after accept.
3. Hold fetch_rsp_ready=0 and issue fetches to addresses 1, 2, 3 -> third request sees fetch_req_ready=0; release ready -> responses for 1 and 2 arrive in order, then 3 is accepted, with no loss or duplication.
4. Drive ld_valid and fetch_req_valid in the same cycle (addr 7, data 19'h00123) -> load written; fetch_req_ready=0 that cycle; the fetch is accepted next cycle and returns 19'h00123.
5. With DEPTH=1000, fetch addr 1010 -> instruction=0, fetch_fault=1, same latency; load to addr 1010 is accepted and memory is unchanged.
6. Assert RESET with 2 fetches outstanding -> fetch_rsp_valid=0 next cycle; sweep restarts; previously loaded data reads back as 0 after init_done.
